// File: rtl/iop_stream_tx.sv
// 128-bit result word to 32-bit AXI-Stream serializer with frame tlast and a done pulse.
// Optional stall counter output enabled by defining IOP_TX_STALL_CNT_EN.
module iop_stream_tx #(
    parameter int pDATA_WIDTH  = 32,
    parameter int pIOPS_WIDTH  = 128,
    parameter int pFRAME_WORDS = 1024,
    parameter int pCNT_WIDTH   = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   narrow,
    output logic                   busy,
    output logic                   done,
    input  logic                   i_vld,
    output logic                   i_rdy,
    input  logic [pIOPS_WIDTH-1:0] i_dat,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast
`ifdef IOP_TX_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [pCNT_WIDTH-1:0] FRAME_WORDS = pCNT_WIDTH'(pFRAME_WORDS);

    state_t                   state_reg, state_next;
    logic                     narrow_reg;
    logic [pIOPS_WIDTH-1:0]   hold_reg;
    logic                     hold_vld_reg;
    logic [1:0]               beat_cnt_reg;
    logic [pCNT_WIDTH-1:0]    word_cnt_reg;
    logic [pDATA_WIDTH-1:0]   lane [4];

    logic frame_start;
    logic final_beat;
    logic beat_fire;
    logic last_beat_fire;
    logic word_accept;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = hold_reg[gi*pDATA_WIDTH +: pDATA_WIDTH];
        end
    endgenerate

    assign frame_start    = (state_reg == ST_IDLE) && start;
    assign final_beat     = narrow_reg || (beat_cnt_reg == 2'd3);
    assign beat_fire      = hold_vld_reg && sm_tready;
    assign last_beat_fire = beat_fire && final_beat;
    // Ready looks through the draining beat so a new word lands with no bubble.
    assign i_rdy          = (state_reg == ST_RUN) && (word_cnt_reg < FRAME_WORDS)
                            && (!hold_vld_reg || last_beat_fire);
    assign word_accept    = i_vld && i_rdy;

    assign sm_tvalid = hold_vld_reg;
    assign sm_tdata  = lane[beat_cnt_reg];
    // word_cnt only reaches the frame size once the final word is the one being held.
    assign sm_tlast  = hold_vld_reg && (word_cnt_reg == FRAME_WORDS) && final_beat;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (beat_fire && sm_tlast) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            narrow_reg   <= 1'b0;
            hold_reg     <= '0;
            hold_vld_reg <= 1'b0;
            beat_cnt_reg <= 2'd0;
            word_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (frame_start) begin
                narrow_reg   <= narrow;
                hold_vld_reg <= 1'b0;
                beat_cnt_reg <= 2'd0;
                word_cnt_reg <= '0;
            end else begin
                if (beat_fire)
                    beat_cnt_reg <= final_beat ? 2'd0 : beat_cnt_reg + 2'd1;
                if (word_accept) begin
                    hold_reg     <= i_dat;
                    hold_vld_reg <= 1'b1;
                    word_cnt_reg <= word_cnt_reg + 1'b1;
                end else if (last_beat_fire) begin
                    hold_vld_reg <= 1'b0;
                end
            end
        end
    end

`ifdef IOP_TX_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_reg <= '0;
        end else if (frame_start) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_RUN) && hold_vld_reg && !sm_tready
                     && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_iop_stream_tx.sv
// Randomized self-checking bench for iop_stream_tx; expected beats come from a queue model
// built from the words the bench hands over.
module tb_iop_stream_tx;

    localparam int DW = 32;
    localparam int IW = 128;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rstn, start, narrow, busy, done;
    logic          i_vld, i_rdy, sm_tvalid, sm_tready, sm_tlast;
    logic [IW-1:0] i_dat;
    logic [DW-1:0] sm_tdata;
`ifdef IOP_TX_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    iop_stream_tx #(
        .pDATA_WIDTH (DW),
        .pIOPS_WIDTH (IW),
        .pFRAME_WORDS(FW),
        .pCNT_WIDTH  (3)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .narrow   (narrow),
        .busy     (busy),
        .done     (done),
        .i_vld    (i_vld),
        .i_rdy    (i_rdy),
        .i_dat    (i_dat),
        .sm_tvalid(sm_tvalid),
        .sm_tready(sm_tready),
        .sm_tdata (sm_tdata),
        .sm_tlast (sm_tlast)
`ifdef IOP_TX_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 streaming, 2 done cycle.
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            phase = 0;
    int            acc = 0;
    bit            narrow_m = 1'b0;
    logic [32:0]   exp_q[$];
    logic [IW-1:0] words[FW+1];
    bit            prev_stall = 1'b0;
    logic [31:0]   prev_data = '0;
    logic          prev_last = 1'b0;
    int            first_acc_cyc = 0;
    int            last_fire_cyc = 0;
    int            fires = 0;
    int            stall_m = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        bit          fire_now, acc_now, tl_fire;
        int          nb;
        logic [32:0] e;
        tl_fire = 1'b0;
        @(negedge clk);
        chk("busy", busy, 64'(phase != 0));
        chk("done", done, 64'(phase == 2));
        if (phase == 2) chk("q_empty_at_done", 64'(exp_q.size()), 0);
        if (phase == 0) begin
            chk("idle_irdy", i_rdy, 0);
            chk("idle_tvalid", sm_tvalid, 0);
        end
        if (acc >= FW) chk("full_irdy", i_rdy, 0);
        if (prev_stall) begin
            chk("stall_tvalid", sm_tvalid, 1);
            chk("stall_tdata", sm_tdata, prev_data);
            chk("stall_tlast", sm_tlast, prev_last);
        end
        fire_now = sm_tvalid && sm_tready;
        acc_now  = i_vld && i_rdy;
        if (fire_now) begin
            fires++;
            last_fire_cyc = cyc;
            chk("beat_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("beat cyc=%0d data=%08h last=%0b exp=%08h/%0b", cyc, sm_tdata, sm_tlast, e[31:0], e[32]);
                chk("tdata", sm_tdata, e[31:0]);
                chk("tlast", sm_tlast, e[32]);
                tl_fire = e[32];
            end
        end
        if (phase == 1 && sm_tvalid && !sm_tready) stall_m++;
        prev_stall = sm_tvalid && !sm_tready;
        prev_data  = sm_tdata;
        prev_last  = sm_tlast;
        if (acc_now) begin
            if (acc == 0) first_acc_cyc = cyc;
            nb = narrow_m ? 1 : 4;
            for (int b = 0; b < nb; b++)
                exp_q.push_back({(acc == FW-1) && (b == nb-1), i_dat[b*32 +: 32]});
            acc++;
        end
        if (phase == 0 && start) begin
            phase = 1; acc = 0; narrow_m = narrow; stall_m = 0; fires = 0;
        end else if (phase == 2) begin
            phase = 0;
        end else if (tl_fire) begin
            phase = 2;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int tr_mode, input bit rnd_vld);
        case (tr_mode)
            0:       sm_tready = 1'b1;
            1:       sm_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: sm_tready = ($urandom_range(0, 2) != 0);
        endcase
        i_vld = rnd_vld ? 1'($urandom_range(0, 1)) : 1'b1;
        i_dat = words[acc > FW ? FW : acc];
    endtask

    task automatic run_frame(input bit nm, input int tr_mode, input bit rnd_vld);
        int budget;
        budget = 0;
        start = 1'b1; narrow = nm;
        drive(tr_mode, rnd_vld);
        tick();
        start = 1'b0; narrow = 1'($urandom_range(0, 1));
        while (phase != 0 && budget < 2000) begin
            drive(tr_mode, rnd_vld);
            tick();
            budget++;
        end
        chk("timeout", 64'(budget >= 2000), 0);
`ifdef IOP_TX_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 64'(stall_m));
`endif
    endtask

    task automatic fill_pattern();
        for (int k = 0; k <= FW; k++)
            words[k] = 128'h33333333_22222222_11111111_00000000 + 128'(k);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; narrow = 1'b0;
        i_vld = 1'b0; i_dat = '0; sm_tready = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_irdy", i_rdy, 0);
        chk("rst_tvalid", sm_tvalid, 0);
        chk("rst_tdata", sm_tdata, 0);
        chk("rst_tlast", sm_tlast, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Input offered while idle must be refused.
        i_vld = 1'b1; i_dat = 128'hDEAD;
        for (int i = 0; i < 5; i++) tick();

        // FFT at full rate, plus a 5th word that must never go out.
        fill_pattern();
        run_frame(1'b0, 0, 1'b0);
        chk("fft_beats", 64'(fires), 16);
        chk("fft_span", 64'(last_fire_cyc - first_acc_cyc), 16);

        // Backpressure 1,0,0,1.
        run_frame(1'b0, 1, 1'b0);
        chk("bp_beats", 64'(fires), 16);

        // NTT mode: low 32 bits only, upper bits are noise.
        for (int k = 0; k <= FW; k++)
            words[k] = {32'($urandom), 32'($urandom), 32'($urandom), 32'h3000 + 32'(k)};
        run_frame(1'b1, 0, 1'b0);
        chk("ntt_beats", 64'(fires), 4);

        // Start ignored in RUN, then reset after 6 beats.
        fill_pattern();
        start = 1'b1; narrow = 1'b0;
        drive(0, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && fires < 6; i++) begin
            drive(0, 1'b0);
            start  = (i == 2);
            narrow = 1'b1;
            tick();
        end
        start = 1'b0;
        chk("pre_reset_beats", 64'(fires), 6);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_irdy", i_rdy, 0);
        chk("mid_rst_tvalid", sm_tvalid, 0);
        chk("mid_rst_tdata", sm_tdata, 0);
        chk("mid_rst_tlast", sm_tlast, 0);
        phase = 0; acc = 0; exp_q.delete(); prev_stall = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        rstn = 1'b1;
        tick();
        run_frame(1'b0, 0, 1'b0);
        chk("clean_beats", 64'(fires), 16);

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k <= FW; k++)
                words[k] = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            run_frame(1'($urandom_range(0, 1)), 2, 1'b1);
            i_vld = 1'b0;
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
